// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scanner for an eight-digit hex display.
// A prescaler sets the dwell time on each digit. A 3-bit index walks digits 0..7.
// Shadow registers hold the displayed value and the enable mask between load strobes.
// Optional feature: define SEG_LZB_EN to blank leading zero digits. Digit 0 is never blanked.
module seg_scan #(
   parameter int CLK_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_in,
   input  logic [7:0]  digit_en,
   input  logic        load,
   output logic [3:0]  code,
   output logic [7:0]  an,
   output logic        frame_done
);

   // A one-bit counter is enough when CLK_DIV=1; it then stays at zero and ticks every cycle.
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] r_presc;
   logic [2:0]       r_idx;
   logic [31:0]      r_dreg;
   logic [7:0]       r_mreg;
   logic             r_frameDone;

   logic             w_tick;
   logic [7:0]       w_oneHot;
   logic [7:0]       w_effMask;

   assign w_tick = (r_presc == LAST);

   // Prescaler: counts 0..CLK_DIV-1 and wraps, producing one tick per dwell.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_presc <= '0;
      else if (w_tick)
         r_presc <= '0;
      else
         r_presc <= r_presc + CNT_W'(1);
   end

   // Digit index: steps once per tick and wraps naturally from 7 to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_idx <= 3'd0;
      else if (w_tick)
         r_idx <= r_idx + 3'd1;
   end

   // Frame pulse: registered so it is high in the cycle after the 7->0 wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_frameDone <= 1'b0;
      else
         r_frameDone <= w_tick && (r_idx == 3'd7);
   end

   // Shadow registers: after reset all digits are enabled and show zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dreg <= 32'h0;
         r_mreg <= 8'hFF;
      end else if (load) begin
         r_dreg <= data_in;
         r_mreg <= digit_en;
      end
   end

   // One-hot decode of the current digit index.
   always_comb begin
      w_oneHot        = 8'h00;
      w_oneHot[r_idx] = 1'b1;
   end

`ifdef SEG_LZB_EN
   logic [7:0] w_keep;

   // Leading-zero blanking: digit k stays lit only if some nibble from k up to 7 is nonzero.
   always_comb begin
      w_keep = 8'h01;
      for (int k = 1; k < 8; k++)
         w_keep[k] = |(r_dreg >> (4 * k));
   end

   assign w_effMask = r_mreg & w_keep;
`else
   assign w_effMask = r_mreg;
`endif

   // A disabled digit still drives its nibble on code; only the anode is kept dark.
   assign code       = r_dreg[{r_idx, 2'b00} +: 4];
   assign an         = ~(w_oneHot & w_effMask);
   assign frame_done = r_frameDone;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed bench for seg_scan with CLK_DIV=4.
// Every cycle, a reference model pushes the expected outputs to a scoreboard queue.
// The DUT outputs are compared against the queue on the following falling edge.
module tb_seg_scan;

   localparam int CLK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_in = 32'h0;
   logic [7:0]  digit_en = 8'h0;
   logic        load = 1'b0;
   logic [3:0]  code;
   logic [7:0]  an;
   logic        frame_done;

   seg_scan #(.CLK_DIV(CLK_DIV)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .digit_en   (digit_en),
      .load       (load),
      .code       (code),
      .an         (an),
      .frame_done (frame_done)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] code;
      logic [7:0] an;
      logic       fd;
   } exp_t;

   exp_t        scoreQ[$];
   int          errors = 0;
   int          checks = 0;
   int          fdCount = 0;

   int          mPresc;
   int          mIdx;
   logic [31:0] mD;
   logic [7:0]  mM;
   logic        mFd;

   // Expected anode pattern for the given digit, including optional blanking.
   function automatic logic [7:0] modelAn(input logic [31:0] d, input logic [7:0] m, input int idx);
      logic [7:0] eff;
      logic [7:0] res;
      eff = m;
`ifdef SEG_LZB_EN
      for (int k = 7; k >= 1; k--) begin
         if (d[4*k +: 4] != 4'h0) break;
         eff[k] = 1'b0;
      end
`endif
      res = 8'hFF;
      if (eff[idx]) res[idx] = 1'b0;
      return res;
   endfunction

   // Reset state of the model, matching an asserted rst_n.
   task automatic modelReset();
      mPresc = 0;
      mIdx   = 0;
      mD     = 32'h0;
      mM     = 8'hFF;
      mFd    = 1'b0;
   endtask

   // Single comparison: counts it, and on mismatch reports and counts a failure.
   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
         $error("[TB] %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Pops the oldest expectation and compares all three outputs against it.
   task automatic checkOutput();
      exp_t e;
      if (scoreQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: observed=empty expected=entry");
      end else begin
         e = scoreQ.pop_front();
         checkValue("sb code", 32'(code), 32'(e.code));
         checkValue("sb an", 32'(an), 32'(e.an));
         checkValue("sb frame_done", 32'(frame_done), 32'(e.fd));
      end
      if (frame_done === 1'b1) fdCount++;
   endtask

   // Drives one clock of stimulus from a falling edge, advances the model, then checks at the next falling edge.
   task automatic applyStimulus(input logic ld, input logic [31:0] d, input logic [7:0] m);
      exp_t e;
      logic tick;
      load     = ld;
      data_in  = d;
      digit_en = m;
      @(posedge clk);
      tick = (mPresc == CLK_DIV - 1);
      if (ld) begin
         mD = d;
         mM = m;
      end
      mFd    = tick && (mIdx == 7);
      mPresc = tick ? 0 : mPresc + 1;
      if (tick) mIdx = (mIdx + 1) % 8;
      e.code = mD[4*mIdx +: 4];
      e.an   = modelAn(mD, mM, mIdx);
      e.fd   = mFd;
      scoreQ.push_back(e);
      @(negedge clk);
      load = 1'b0;
      checkOutput();
   endtask

   // Idle cycle: data_in and digit_en wander randomly but load stays low.
   task automatic idleCycle();
      applyStimulus(1'b0, $urandom, 8'($urandom));
   endtask

   // Directed test sequence.
   initial begin
      logic [7:0] expAn;
      int         guard;

      $display("[TB] start");
      modelReset();
      #12;
      checkValue("reset code", 32'(code), 32'h0);
      checkValue("reset an", 32'(an), 32'hFE);
      checkValue("reset frame_done", 32'(frame_done), 32'h0);

      @(negedge clk);
      rst_n = 1'b1;

      // The load on the first edge after reset must take effect; then walk one whole frame.
      fdCount = 0;
      applyStimulus(1'b1, 32'h12345678, 8'hFF);
      for (int k = 0; k < 8; k++) begin
         expAn = ~(8'h01 << k);
         checkValue("basic code", 32'(code), 32'(8 - k));
         checkValue("basic an", 32'(an), 32'(expAn));
         for (int c = 0; c < 4; c++) idleCycle();
      end
      checkValue("frame pulses first frame", 32'(fdCount), 32'd1);
      for (int c = 0; c < 32; c++) idleCycle();
      checkValue("frame pulses second frame", 32'(fdCount), 32'd2);

      // Masking: upper four digits dark while code still carries their nibbles.
      applyStimulus(1'b1, 32'h12345678, 8'h0F);
      for (int c = 0; c < 32; c++) begin
         idleCycle();
         if (mIdx >= 4) begin
            checkValue("mask an", 32'(an), 32'hFF);
            checkValue("mask code", 32'(code), 32'(8 - mIdx));
         end
      end

      // Load coincident with the tick that leaves index 2.
      guard = 0;
      while (!(mIdx == 2 && mPresc == CLK_DIV - 1) && guard < 64) begin
         idleCycle();
         guard++;
      end
      checkValue("sync to index 2 tick", 32'(guard < 64), 32'd1);
      applyStimulus(1'b1, 32'hAAAAAAAA, 8'hFF);
      checkValue("tick load code", 32'(code), 32'hA);
      checkValue("tick load an", 32'(an), 32'hF7);

      // Leading-zero blanking.
      applyStimulus(1'b1, 32'h00000A05, 8'hFF);
      for (int c = 0; c < 32; c++) begin
         idleCycle();
         expAn = ~(8'h01 << mIdx);
`ifdef SEG_LZB_EN
         if (mIdx >= 3) expAn = 8'hFF;
`endif
         checkValue("blank an", 32'(an), 32'(expAn));
         if (mIdx == 1) checkValue("blank digit1 code", 32'(code), 32'h0);
      end

      // Asynchronous reset in the middle of digit 5.
      guard = 0;
      while (mIdx != 5 && guard < 64) begin
         idleCycle();
         guard++;
      end
      checkValue("sync to index 5", 32'(guard < 64), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkValue("async reset an", 32'(an), 32'hFE);
      checkValue("async reset code", 32'(code), 32'h0);
      checkValue("async reset frame_done", 32'(frame_done), 32'h0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         idleCycle();
         checkValue("post reset dwell an", 32'(an), 32'hFE);
      end
      idleCycle();
      checkValue("post reset first tick an", 32'(an), 32'hFD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000: clk cycles per digit dwell; legal range 1..2^20.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port data_in, input, 32 bits: eight hex digits; digit k = data_in[4k+3:4k], digit 0 rightmost.
REQ-005 The block SHALL have port digit_en, input, 8 bits: per-digit enable mask, bit k enables digit k.
REQ-006 The block SHALL have port load, input, 1 bit: 1-cycle strobe that captures data_in and digit_en.
REQ-007 The block SHALL have port code, output, 4 bits: hex value of the currently scanned digit, fed to the downstream segment-pattern decoder.
REQ-008 The block SHALL have port an, output, 8 bits: active-low anode select; bit k low means digit k is lit.
REQ-009 The block SHALL have port frame_done, output, 1 bit: 1-cycle pulse at the end of each full 8-digit scan.

Function
REQ-010 The block SHALL contain a prescaler counting 0..CLK_DIV-1 that wraps to 0; tick is asserted in the cycle the count equals CLK_DIV-1.
REQ-011 CLK_DIV=1 SHALL produce a tick every cycle.
REQ-012 The block SHALL contain a 3-bit digit index that advances by 1 on each tick and wraps from 7 to 0.
REQ-013 frame_done SHALL be registered and high for exactly the one cycle after the edge on which the index wraps 7->0.
REQ-014 On a clk edge with load=1, data_in SHALL be captured into shadow register dreg and digit_en into mreg; load=0 SHALL hold both.
REQ-015 code SHALL equal nibble [index] of dreg, combinationally from registered state; new load data SHALL be visible on code one cycle after the load edge.
REQ-016 an SHALL equal the bitwise inverse of (one-hot(index) AND effective mask); at most one bit of an SHALL be low.
REQ-017 The effective mask SHALL equal mreg when SEG_LZB_EN is undefined (REQ-024).
REQ-018 When a digit is disabled, code SHALL still carry its nibble, and an SHALL be 8'hFF for that dwell.
REQ-019 If load and tick occur on the same edge, both SHALL take effect; the new index SHALL show the new data.
REQ-020 Changes on data_in and digit_en without load SHALL have no effect on any output.

Reset
REQ-021 When rst_n is low, the block SHALL immediately, without waiting for clk, force prescaler=0, index=0, dreg=32'h0, mreg=8'hFF and frame_done=0; outputs SHALL then be code=4'h0 and an=8'hFE.
REQ-022 Reset asserted mid-dwell or mid-frame SHALL abort the scan; the scan SHALL restart at digit 0 with a full CLK_DIV dwell after rst_n deasserts.
REQ-023 A load in the first clk edge after rst_n deasserts SHALL be honoured.

Configuration
REQ-024 With macro SEG_LZB_EN defined, leading-zero blanking SHALL be enabled: digit k (k>=1) is suppressed when dreg nibbles k..7 are all zero; effective mask = mreg AND the non-suppressed set; digit 0 SHALL never be suppressed by blanking.
REQ-025 With SEG_LZB_EN undefined, no blanking logic SHALL be present, and the effective mask SHALL be mreg only.

Verification (CLK_DIV=4 for simulation)
REQ-026 Bench SHALL cover reset: hold rst_n=0 -> code=0, an=8'hFE, frame_done=0; assert rst_n async mid-cycle -> outputs change before the next clk edge.
REQ-027 Bench SHALL cover a basic scan: load data_in=32'h12345678, digit_en=8'hFF -> code steps 8,7,6,5,4,3,2,1 every 4 cycles; an steps FE,FD,FB,F7,EF,DF,BF,7F; frame_done pulses once per 32 cycles after the 7->0 wrap.
REQ-028 Bench SHALL cover masking: load digit_en=8'h0F -> an=8'hFF during dwells 4..7 while code still shows those nibbles.
REQ-029 Bench SHALL cover load coincident with tick: pulse load with 32'hAAAAAAAA on the tick edge at index 2 -> index 3 dwell shows code=4'hA.
REQ-030 Bench SHALL cover blanking: load 32'h00000A05, digit_en=8'hFF -> with SEG_LZB_EN, digits 3..7 give an=8'hFF and digits 0..2 are lit (digit 1 shows code 0); without the macro all eight digits are lit.
REQ-031 Bench SHALL cover reset mid-frame: drop rst_n at index 5 -> an=8'hFE at once; after release, the first tick occurs 4 cycles later with an=8'hFD.
